// File: rtl/rom_pic_reader.sv
// Reads a fixed picture window out of a registered-read ROM in step with HDMI timing
// and re-times vs/hs/de so they line up with the returned pixel.
module rom_pic_reader #(
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int X_START    = 0,
  parameter int Y_START    = 0,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vs_in,
  input  logic                  hs_in,
  input  logic                  de_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  vs_out,
  output logic                  hs_out,
  output logic                  de_out,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_in_win,
  output logic                  frame_done
);

  localparam int CNT_W = 16;
  localparam int NST   = 1 + RD_LATENCY;
  localparam int DW    = CNT_W + 2;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(IMG_W * IMG_H - 1);

  logic                  vs_prev_q, vs_prev_d;
  logic                  de_prev_q, de_prev_d;
  logic                  frame_seen_q, frame_seen_d;
  logic [CNT_W-1:0]      hcnt_q, hcnt_d;
  logic [CNT_W-1:0]      vcnt_q, vcnt_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [NST-1:0]        vs_pipe_q, vs_pipe_d;
  logic [NST-1:0]        hs_pipe_q, hs_pipe_d;
  logic [NST-1:0]        de_pipe_q, de_pipe_d;
  logic [NST-1:0]        win_pipe_q, win_pipe_d;
  logic [NST-1:0]        last_pipe_q, last_pipe_d;

  logic                  vs_rise;
  logic                  seen_cur;
  logic [CNT_W-1:0]      hcnt_cur, vcnt_cur;
  logic [ADDR_WIDTH-1:0] ptr_cur;
  logic [DW-1:0]         dx, dy;
  logic                  in_x, in_y, win, last;

  always_comb begin
    // A frame start overrides the counters and pointer in the same cycle it is seen.
    vs_rise  = vs_in & ~vs_prev_q;
    hcnt_cur = vs_rise ? '0 : hcnt_q;
    vcnt_cur = vs_rise ? '0 : vcnt_q;
    ptr_cur  = vs_rise ? '0 : ptr_q;
    seen_cur = frame_seen_q | vs_rise;

    // Signed offsets into the window avoid constant compares when the origin is 0.
    dx   = {2'b00, hcnt_cur} - DW'(X_START);
    dy   = {2'b00, vcnt_cur} - DW'(Y_START);
    in_x = ~dx[DW-1] && (dx < DW'(IMG_W));
    in_y = ~dy[DW-1] && (dy < DW'(IMG_H));
    win  = seen_cur & de_in & in_x & in_y;
    last = win && (ptr_cur == PTR_LAST);

    vs_prev_d    = vs_in;
    de_prev_d    = de_in;
    frame_seen_d = seen_cur;
    hcnt_d       = '0;
    vcnt_d       = vcnt_cur;
    ptr_d        = ptr_cur;
    rom_addr_d   = rom_addr_q;

    if (de_in) begin
      hcnt_d = (hcnt_cur == '1) ? hcnt_cur : hcnt_cur + 1'b1;
    end
    if (de_prev_q && !de_in && (vcnt_cur != '1)) begin
      vcnt_d = vcnt_cur + 1'b1;
    end
    if (win) begin
      rom_addr_d = ptr_cur;
      ptr_d      = last ? '0 : ptr_cur + 1'b1;
    end

    vs_pipe_d   = {vs_pipe_q[NST-2:0], vs_in};
    hs_pipe_d   = {hs_pipe_q[NST-2:0], hs_in};
    de_pipe_d   = {de_pipe_q[NST-2:0], de_in};
    win_pipe_d  = {win_pipe_q[NST-2:0], win};
    last_pipe_d = {last_pipe_q[NST-2:0], last};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q    <= 1'b0;
      de_prev_q    <= 1'b0;
      frame_seen_q <= 1'b0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      ptr_q        <= '0;
      rom_addr_q   <= '0;
      vs_pipe_q    <= '0;
      hs_pipe_q    <= '0;
      de_pipe_q    <= '0;
      win_pipe_q   <= '0;
      last_pipe_q  <= '0;
    end else begin
      vs_prev_q    <= vs_prev_d;
      de_prev_q    <= de_prev_d;
      frame_seen_q <= frame_seen_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      ptr_q        <= ptr_d;
      rom_addr_q   <= rom_addr_d;
      vs_pipe_q    <= vs_pipe_d;
      hs_pipe_q    <= hs_pipe_d;
      de_pipe_q    <= de_pipe_d;
      win_pipe_q   <= win_pipe_d;
      last_pipe_q  <= last_pipe_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign vs_out     = vs_pipe_q[NST-1];
  assign hs_out     = hs_pipe_q[NST-1];
  assign de_out     = de_pipe_q[NST-1];
  assign pix_in_win = win_pipe_q[NST-1];
  assign frame_done = last_pipe_q[NST-1];

  // ROM data arrives in the final stage, so the mux is combinational; reset forces zero.
  assign pix_data = rst ? '0 : (win_pipe_q[NST-1] ? rom_data : BG_COLOR);

endmodule
